// File: rtl/ahb_default_slave_pkg.sv
// ahb_default_slave_pkg: shared AHB transfer-type and response encodings.
// Revision: 1.0
`default_nettype none

package ahb_default_slave_pkg;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic [1:0] HRESP_OKAY  = 2'b00;
    localparam logic [1:0] HRESP_ERROR = 2'b01;

endpackage

`default_nettype wire

// File: rtl/ahb_default_slave.sv
// ahb_default_slave: bus-matrix slave 0, answers unmapped accesses with ERROR
// and records the first offending access plus a saturating error count.
// Revision: 1.0
`default_nettype none

module ahb_default_slave
    import ahb_default_slave_pkg::*;
#(
    parameter int          WAIT_CYCLES = 0,
    parameter int          CNT_W       = 8,
    parameter logic [31:0] RDATA_VALUE = 32'h0000_0000
) (
    input  logic             HCLK,
    input  logic             HRESETn,
    input  logic             HSEL,
    input  logic [31:0]      HADDR,
    input  logic [1:0]       HTRANS,
    input  logic             HWRITE,
    input  logic             HREADY,
    output logic             HREADYOUT,
    output logic [1:0]       HRESP,
    output logic [31:0]      HRDATA,
    input  logic             err_clr,
    output logic             err_irq,
    output logic [31:0]      err_addr,
    output logic             err_write,
    output logic [CNT_W-1:0] err_count
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_WAIT = 2'd1;
    localparam logic [1:0] ST_ERR1 = 2'd2;
    localparam logic [1:0] ST_ERR2 = 2'd3;

    localparam logic [1:0]       FIRST_ST = (WAIT_CYCLES > 0) ? ST_WAIT : ST_ERR1;
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    logic [1:0]       state_q, state_d;
    logic             take;
    logic             wait_done;
    logic             err_irq_q, err_irq_d;
    logic [31:0]      err_addr_q, err_addr_d;
    logic             err_write_q, err_write_d;
    logic [CNT_W-1:0] err_count_q, err_count_d;

    // Address phases are only sampled while this slave is free to take one.
    assign take = HSEL && HREADY
                  && ((HTRANS == HTRANS_NONSEQ) || (HTRANS == HTRANS_SEQ))
                  && ((state_q == ST_IDLE) || (state_q == ST_ERR2));

    generate
        if (WAIT_CYCLES > 0) begin : g_wait_cnt
            logic [3:0] wait_cnt_q, wait_cnt_d;

            always_comb begin
                wait_cnt_d = wait_cnt_q;
                if (take) begin
                    wait_cnt_d = 4'(WAIT_CYCLES);
                end else if (state_q == ST_WAIT) begin
                    wait_cnt_d = wait_cnt_q - 4'd1;
                end
            end

            always_ff @(posedge HCLK) begin
                if (!HRESETn) begin
                    wait_cnt_q <= 4'd0;
                end else begin
                    wait_cnt_q <= wait_cnt_d;
                end
            end

            assign wait_done = (wait_cnt_q == 4'd1);
        end else begin : g_no_wait
            assign wait_done = 1'b1;
        end
    endgenerate

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (take) state_d = FIRST_ST;
            ST_WAIT: if (wait_done) state_d = ST_ERR1;
            ST_ERR1: state_d = ST_ERR2;
            ST_ERR2: state_d = take ? FIRST_ST : ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        HREADYOUT = 1'b1;
        HRESP     = HRESP_OKAY;
        case (state_q)
            ST_WAIT: HREADYOUT = 1'b0;
            ST_ERR1: begin
                HREADYOUT = 1'b0;
                HRESP     = HRESP_ERROR;
            end
            ST_ERR2: HRESP = HRESP_ERROR;
            default: ;
        endcase
    end

    // A clear coinciding with a new error restarts the record from that error.
    always_comb begin
        err_irq_d   = err_irq_q;
        err_addr_d  = err_addr_q;
        err_write_d = err_write_q;
        err_count_d = err_count_q;
        if (err_clr) begin
            err_irq_d   = 1'b0;
            err_count_d = '0;
        end
        if (take) begin
            err_irq_d = 1'b1;
            if (err_clr) begin
                err_count_d = CNT_ONE;
            end else if (err_count_q != CNT_MAX) begin
                err_count_d = err_count_q + CNT_ONE;
            end
            if (!err_irq_q || err_clr) begin
                err_addr_d  = HADDR;
                err_write_d = HWRITE;
            end
        end
    end

    always_ff @(posedge HCLK) begin
        if (!HRESETn) begin
            state_q     <= ST_IDLE;
            err_irq_q   <= 1'b0;
            err_addr_q  <= 32'h0;
            err_write_q <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            err_irq_q   <= err_irq_d;
            err_addr_q  <= err_addr_d;
            err_write_q <= err_write_d;
            err_count_q <= err_count_d;
        end
    end

    assign HRDATA    = RDATA_VALUE;
    assign err_irq   = err_irq_q;
    assign err_addr  = err_addr_q;
    assign err_write = err_write_q;
    assign err_count = err_count_q;

endmodule

`default_nettype wire

// File: tb/tb_ahb_default_slave.sv
// tb_ahb_default_slave: directed checks of three default-slave configurations
// (W=0/CNT_W=8, W=3/CNT_W=8, W=0/CNT_W=2) driven from one shared bus.
// Revision: 1.0
`default_nettype none

module tb_ahb_default_slave;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        HSEL = 1'b0;
    logic [31:0] HADDR = 32'h0;
    logic [1:0]  HTRANS = 2'b00;
    logic        HWRITE = 1'b0;
    logic        HREADY = 1'b1;
    logic        err_clr = 1'b0;

    logic        a_rdy, b_rdy, c_rdy;
    logic [1:0]  a_resp, b_resp, c_resp;
    logic [31:0] a_rdata, b_rdata, c_rdata;
    logic        a_irq, b_irq, c_irq;
    logic [31:0] a_addr, b_addr, c_addr;
    logic        a_wr, b_wr, c_wr;
    logic [7:0]  a_cnt, b_cnt;
    logic [1:0]  c_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 HCLK = ~HCLK;

    ahb_default_slave #(.WAIT_CYCLES(0), .CNT_W(8), .RDATA_VALUE(32'hDEAD_BEEF)) u_dut_a (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HREADYOUT(a_rdy), .HRESP(a_resp),
        .HRDATA(a_rdata), .err_clr(err_clr), .err_irq(a_irq), .err_addr(a_addr),
        .err_write(a_wr), .err_count(a_cnt));

    ahb_default_slave #(.WAIT_CYCLES(3), .CNT_W(8), .RDATA_VALUE(32'h0000_0000)) u_dut_b (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HREADYOUT(b_rdy), .HRESP(b_resp),
        .HRDATA(b_rdata), .err_clr(err_clr), .err_irq(b_irq), .err_addr(b_addr),
        .err_write(b_wr), .err_count(b_cnt));

    ahb_default_slave #(.WAIT_CYCLES(0), .CNT_W(2), .RDATA_VALUE(32'h1234_5678)) u_dut_c (
        .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
        .HWRITE(HWRITE), .HREADY(HREADY), .HREADYOUT(c_rdy), .HRESP(c_resp),
        .HRDATA(c_rdata), .err_clr(err_clr), .err_irq(c_irq), .err_addr(c_addr),
        .err_write(c_wr), .err_count(c_cnt));

    task automatic tick();
        @(posedge HCLK);
        #1;
    endtask

    task automatic bus_idle();
        HSEL = 1'b0; HTRANS = 2'b00; HREADY = 1'b1; err_clr = 1'b0; HWRITE = 1'b0;
    endtask

    task automatic do_reset();
        bus_idle();
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
    endtask

    // Drives one NONSEQ with W=0 timing and returns the bus to IDLE afterwards.
    task automatic error_xfer(input logic [31:0] addr, input logic wr);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = addr; HWRITE = wr; HREADY = 1'b1;
        tick();
        HTRANS = 2'b00; HREADY = 1'b0; err_clr = 1'b0;
        tick();
        HREADY = 1'b1;
        tick();
    endtask

    task automatic test_reset();
        bus_idle();
        HRESETn = 1'b0;
        tick();
        n_checks++;
        if ({a_rdy, a_resp, a_irq, a_cnt} !== {1'b1, 2'b00, 1'b0, 8'd0}) begin
            n_fail++;
            $display("FAIL reset_a: rdy/resp/irq/cnt got %b/%b/%b/%0d want 1/00/0/0", a_rdy, a_resp, a_irq, a_cnt);
        end
        n_checks++;
        if ({a_addr, a_wr} !== {32'h0, 1'b0}) begin
            n_fail++;
            $display("FAIL reset_addr: got %h/%b want 00000000/0", a_addr, a_wr);
        end
        n_checks++;
        if ({a_rdata, c_rdata} !== {32'hDEAD_BEEF, 32'h1234_5678}) begin
            n_fail++;
            $display("FAIL reset_rdata: got %h/%h want deadbeef/12345678", a_rdata, c_rdata);
        end
        n_checks++;
        if ({b_rdy, b_resp, c_rdy, c_resp} !== {1'b1, 2'b00, 1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL reset_bc: got %b/%b %b/%b want 1/00 1/00", b_rdy, b_resp, c_rdy, c_resp);
        end
        HRESETn = 1'b1;
    endtask

    task automatic test_single_error();
        do_reset();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h4000_0010; HWRITE = 1'b1; HREADY = 1'b1;
        tick();
        n_checks++;
        if ({a_rdy, a_resp} !== {1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL single_err1: rdy/resp got %b/%b want 0/01", a_rdy, a_resp);
        end
        n_checks++;
        if ({a_addr, a_wr, a_cnt, a_irq} !== {32'h4000_0010, 1'b1, 8'd1, 1'b1}) begin
            n_fail++;
            $display("FAIL single_capture: addr/wr/cnt/irq got %h/%b/%0d/%b want 40000010/1/1/1", a_addr, a_wr, a_cnt, a_irq);
        end
        HTRANS = 2'b00; HREADY = 1'b0; HWRITE = 1'b0;
        tick();
        n_checks++;
        if ({a_rdy, a_resp} !== {1'b1, 2'b01}) begin
            n_fail++;
            $display("FAIL single_err2: rdy/resp got %b/%b want 1/01", a_rdy, a_resp);
        end
        HREADY = 1'b1;
        tick();
        n_checks++;
        if ({a_rdy, a_resp} !== {1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL single_idle: rdy/resp got %b/%b want 1/00", a_rdy, a_resp);
        end
    endtask

    task automatic test_idle_busy();
        logic [1:0] kinds [2];
        kinds[0] = 2'b00;
        kinds[1] = 2'b01;
        for (int k = 0; k < 2; k++) begin
            HSEL = 1'b1; HTRANS = kinds[k]; HADDR = 32'h5000_0000; HREADY = 1'b1;
            tick();
            n_checks++;
            if ({a_rdy, a_resp, a_cnt} !== {1'b1, 2'b00, 8'd1}) begin
                n_fail++;
                $display("FAIL idle_busy[%0d]: rdy/resp/cnt got %b/%b/%0d want 1/00/1", k, a_rdy, a_resp, a_cnt);
            end
        end
        bus_idle();
    endtask

    task automatic test_wait_states();
        do_reset();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h6000_0004; HWRITE = 1'b0; HREADY = 1'b1;
        tick();
        HTRANS = 2'b00; HREADY = 1'b0;
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if ({b_rdy, b_resp} !== {1'b0, 2'b00}) begin
                n_fail++;
                $display("FAIL wait[%0d]: rdy/resp got %b/%b want 0/00", i, b_rdy, b_resp);
            end
            tick();
        end
        n_checks++;
        if ({b_rdy, b_resp} !== {1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL wait_err1: rdy/resp got %b/%b want 0/01", b_rdy, b_resp);
        end
        tick();
        n_checks++;
        if ({b_rdy, b_resp, b_cnt, b_addr} !== {1'b1, 2'b01, 8'd1, 32'h6000_0004}) begin
            n_fail++;
            $display("FAIL wait_err2: rdy/resp/cnt/addr got %b/%b/%0d/%h want 1/01/1/60000004", b_rdy, b_resp, b_cnt, b_addr);
        end
        HREADY = 1'b1;
        tick();
        n_checks++;
        if ({b_rdy, b_resp} !== {1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL wait_idle: rdy/resp got %b/%b want 1/00", b_rdy, b_resp);
        end
        bus_idle();
    endtask

    task automatic test_back_to_back();
        do_reset();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h1; HWRITE = 1'b0; HREADY = 1'b1;
        tick();
        HTRANS = 2'b00; HREADY = 1'b0;
        tick();
        HTRANS = 2'b10; HADDR = 32'h2; HWRITE = 1'b1; HREADY = 1'b1;
        tick();
        n_checks++;
        if ({a_rdy, a_resp} !== {1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL b2b_err1: rdy/resp got %b/%b want 0/01", a_rdy, a_resp);
        end
        n_checks++;
        if ({a_addr, a_wr, a_cnt} !== {32'h1, 1'b0, 8'd2}) begin
            n_fail++;
            $display("FAIL b2b_capture: addr/wr/cnt got %h/%b/%0d want 00000001/0/2", a_addr, a_wr, a_cnt);
        end
        HTRANS = 2'b00; HREADY = 1'b0;
        tick();
        HREADY = 1'b1;
        tick();
        bus_idle();
    endtask

    task automatic test_saturation();
        do_reset();
        for (int i = 1; i <= 5; i++) begin
            error_xfer(32'h100 + 32'(i), 1'b0);
            n_checks++;
            if (c_cnt !== ((i < 3) ? 2'(i) : 2'd3)) begin
                n_fail++;
                $display("FAIL sat_cnt[%0d]: got %0d want %0d", i, c_cnt, (i < 3) ? i : 3);
            end
        end
        n_checks++;
        if (c_addr !== 32'h101) begin
            n_fail++;
            $display("FAIL sat_first_addr: got %h want 00000101", c_addr);
        end
        bus_idle();
    endtask

    task automatic test_clear_gating_reset();
        do_reset();
        error_xfer(32'h20, 1'b1);
        error_xfer(32'h24, 1'b0);
        err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if ({a_irq, a_cnt, a_addr, a_wr} !== {1'b0, 8'd0, 32'h20, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_only: irq/cnt/addr/wr got %b/%0d/%h/%b want 0/0/00000020/1", a_irq, a_cnt, a_addr, a_wr);
        end
        error_xfer(32'h28, 1'b0);
        error_xfer(32'h2C, 1'b1);
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h30; HWRITE = 1'b1; HREADY = 1'b1; err_clr = 1'b1;
        tick();
        err_clr = 1'b0;
        n_checks++;
        if ({a_irq, a_cnt, a_addr, a_wr} !== {1'b1, 8'd1, 32'h30, 1'b1}) begin
            n_fail++;
            $display("FAIL clr_accept: irq/cnt/addr/wr got %b/%0d/%h/%b want 1/1/00000030/1", a_irq, a_cnt, a_addr, a_wr);
        end
        HTRANS = 2'b00; HREADY = 1'b0;
        tick();
        HREADY = 1'b1;
        tick();
        HSEL = 1'b1; HTRANS = 2'b10; HADDR = 32'h40; HREADY = 1'b0;
        tick();
        n_checks++;
        if ({a_rdy, a_resp, a_cnt} !== {1'b1, 2'b00, 8'd1}) begin
            n_fail++;
            $display("FAIL hready_gate: rdy/resp/cnt got %b/%b/%0d want 1/00/1", a_rdy, a_resp, a_cnt);
        end
        HREADY = 1'b1;
        tick();
        n_checks++;
        if ({a_rdy, a_resp} !== {1'b0, 2'b01}) begin
            n_fail++;
            $display("FAIL mid_err1: rdy/resp got %b/%b want 0/01", a_rdy, a_resp);
        end
        bus_idle();
        HRESETn = 1'b0;
        tick();
        HRESETn = 1'b1;
        n_checks++;
        if ({a_rdy, a_resp, a_cnt, a_irq} !== {1'b1, 2'b00, 8'd0, 1'b0}) begin
            n_fail++;
            $display("FAIL mid_reset: rdy/resp/cnt/irq got %b/%b/%0d/%b want 1/00/0/0", a_rdy, a_resp, a_cnt, a_irq);
        end
        tick();
        n_checks++;
        if ({a_rdy, a_resp} !== {1'b1, 2'b00}) begin
            n_fail++;
            $display("FAIL post_reset: rdy/resp got %b/%b want 1/00", a_rdy, a_resp);
        end
    endtask

    initial begin
        test_reset();
        test_single_error();
        test_idle_busy();
        test_wait_states();
        test_back_to_back();
        test_saturation();
        test_clear_gating_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
